// File: rtl/l2_cacheline_adaptor.sv
`default_nettype none
// ============================================================================
//  Module   : l2_cacheline_adaptor
//  Purpose  : Bridges single-transfer 256-bit L2 line requests (fill or
//             writeback) onto a 4 x 64-bit beat burst memory interface.
//             Completion is signalled with a one-cycle resp_o pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module l2_cacheline_adaptor #(
    parameter int unsigned BEATS  = 4,
    parameter int unsigned BEAT_W = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    // line side (L2 pmem_* signals)
    input  logic [31:0]              address_i,
    input  logic                     read_i,
    input  logic                     write_i,
    input  logic [BEATS*BEAT_W-1:0]  line_i,
    output logic [BEATS*BEAT_W-1:0]  line_o,
    output logic                     resp_o,
    // burst side (main memory)
    output logic [31:0]              address_o,
    output logic                     read_o,
    output logic                     write_o,
    output logic [BEAT_W-1:0]        burst_o,
    input  logic [BEAT_W-1:0]        burst_i,
    input  logic                     resp_i
);

    // Line width is expected to be 256 bits (32 bytes per line).
    localparam int unsigned c_LINE_W  = BEATS * BEAT_W;
    localparam int unsigned c_CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    // Clears the byte-offset bits of a line address.
    localparam logic [31:0] c_ADDR_MASK = ~(32'(c_LINE_W / 8) - 32'd1);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(BEATS - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RD   = 2'd1;
    localparam logic [1:0] c_WR   = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    logic [1:0]          r_state;
    logic [1:0]          w_state_next;
    logic [31:0]         r_addr;
    logic [c_LINE_W-1:0] r_line;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                w_last_beat;

    // The final beat is the one that arrives while the counter sits at BEATS-1.
    assign w_last_beat = resp_i && (r_cnt == c_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a writeback takes priority over a fill in IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (write_i) begin
                    w_state_next = c_WR;
                end else if (read_i) begin
                    w_state_next = c_RD;
                end
            end
            c_RD: begin
                if (w_last_beat) begin
                    w_state_next = c_DONE;
                end
            end
            c_WR: begin
                if (w_last_beat) begin
                    w_state_next = c_DONE;
                end
            end
            c_DONE: begin
                w_state_next = c_IDLE;
            end
            default: begin
                w_state_next = c_IDLE;
            end
        endcase
    end

    // Address latch, line buffer and beat counter; the counter saturates on
    // the last beat so it never wraps inside a transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr <= '0;
            r_line <= '0;
            r_cnt  <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (write_i) begin
                        r_addr <= address_i & c_ADDR_MASK;
                        r_line <= line_i;
                        r_cnt  <= '0;
                    end else if (read_i) begin
                        r_addr <= address_i & c_ADDR_MASK;
                        r_cnt  <= '0;
                    end
                end
                c_RD: begin
                    if (resp_i) begin
                        r_line[r_cnt*BEAT_W +: BEAT_W] <= burst_i;
                        if (r_cnt != c_LAST) begin
                            r_cnt <= r_cnt + c_CNT_W'(1);
                        end
                    end
                end
                c_WR: begin
                    if (resp_i && (r_cnt != c_LAST)) begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    // Outputs depend only on registered state, never on the request inputs.
    assign read_o    = (r_state == c_RD);
    assign write_o   = (r_state == c_WR);
    assign resp_o    = (r_state == c_DONE);
    assign address_o = r_addr;
    assign line_o    = r_line;
    assign burst_o   = r_line[r_cnt*BEAT_W +: BEAT_W];

endmodule
`default_nettype wire

// File: tb/tb_l2_cacheline_adaptor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_l2_cacheline_adaptor
//  Purpose  : Self-checking bench for l2_cacheline_adaptor. A line-level
//             reference (expected address, buffer contents, beat ordering and
//             completion timing) is kept here and compared against the DUT.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_l2_cacheline_adaptor;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic         resp_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic [63:0]  burst_o;
    logic [63:0]  burst_i;
    logic         resp_i;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: what the adaptor should be holding.
    logic [31:0]  exp_addr;
    logic [255:0] exp_buf;

    l2_cacheline_adaptor dut (
        .clk       (clk),
        .rst       (rst),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .line_i    (line_i),
        .line_o    (line_o),
        .resp_o    (resp_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .burst_o   (burst_o),
        .burst_i   (burst_i),
        .resp_i    (resp_i)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [255:0] rnd256();
        return {rnd64(), rnd64(), rnd64(), rnd64()};
    endfunction

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete line transfer, starting from an IDLE cycle.
    // mode 0: ack every cycle, 1: ack pattern from mask (then always ack),
    // 2: random acks. If also_read is set, read_i stays high throughout
    // (and after) so that a fill follows.
    task automatic transfer(input bit is_wr, input logic [31:0] addr,
                            input logic [255:0] data, input int mode,
                            input logic [31:0] mask, input bit also_read,
                            input string name);
        int  k;
        int  cyc;
        bit  ack;
        logic [255:0] line_model;
        write_i   = is_wr;
        read_i    = !is_wr || also_read;
        address_i = addr;
        line_i    = is_wr ? data : rnd256();
        resp_i    = 1'($urandom_range(0, 1));   // ignored in IDLE
        burst_i   = rnd64();
        step();
        // Request accepted; the line-side values are now irrelevant.
        exp_addr   = addr & 32'hFFFF_FFE0;
        line_model = exp_buf;
        address_i  = $urandom;
        line_i     = rnd256();
        k   = 0;
        cyc = 0;
        while (k < 4 && cyc < 100) begin
            n_checks++;
            if (read_o !== !is_wr || write_o !== is_wr) begin
                n_fail++;
                $display("FAIL %s req_strobes cyc=%0d: read_o=%b write_o=%b, required read_o=%b write_o=%b",
                         name, cyc, read_o, write_o, !is_wr, is_wr);
            end
            n_checks++;
            if (resp_o !== 1'b0) begin
                n_fail++;
                $display("FAIL %s early_resp cyc=%0d: resp_o=%b, required 0", name, cyc, resp_o);
            end
            n_checks++;
            if (address_o !== exp_addr) begin
                n_fail++;
                $display("FAIL %s address_o cyc=%0d: got %h, required %h", name, cyc, address_o, exp_addr);
            end
            if (is_wr) begin
                n_checks++;
                if (burst_o !== data[k*64 +: 64]) begin
                    n_fail++;
                    $display("FAIL %s burst_o beat=%0d: got %h, required %h", name, k, burst_o, data[k*64 +: 64]);
                end
            end
            case (mode)
                0:       ack = 1'b1;
                1:       ack = (cyc < 32) ? mask[cyc] : 1'b1;
                default: ack = ($urandom_range(0, 2) != 0);
            endcase
            resp_i  = ack;
            burst_i = (ack && !is_wr) ? data[k*64 +: 64] : rnd64();
            step();
            if (ack) begin
                if (!is_wr) line_model[k*64 +: 64] = data[k*64 +: 64];
                k++;
            end
            cyc++;
        end
        n_checks++;
        if (k < 4) begin
            n_fail++;
            $display("FAIL %s beat_timeout: beats=%0d, required 4", name, k);
        end
        if (is_wr) line_model = data;
        exp_buf = line_model;
        // DONE cycle: exactly one cycle after the final beat.
        n_checks++;
        if (resp_o !== 1'b1 || read_o !== 1'b0 || write_o !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done_cycle: resp_o=%b read_o=%b write_o=%b, required 1 0 0",
                     name, resp_o, read_o, write_o);
        end
        if (!is_wr) begin
            n_checks++;
            if (line_o !== exp_buf) begin
                n_fail++;
                $display("FAIL %s line_o: got %h, required %h", name, line_o, exp_buf);
            end
        end
        write_i = 1'b0;
        read_i  = also_read;
        resp_i  = 1'($urandom_range(0, 1));   // ignored in DONE
        burst_i = rnd64();
        step();
        resp_i = 1'b0;
        // Back in IDLE: the pulse must not repeat and the buffer must hold.
        n_checks++;
        if (resp_o !== 1'b0 || read_o !== 1'b0 || write_o !== 1'b0) begin
            n_fail++;
            $display("FAIL %s after_done: resp_o=%b read_o=%b write_o=%b, required 0 0 0",
                     name, resp_o, read_o, write_o);
        end
        n_checks++;
        if (line_o !== exp_buf || address_o !== exp_addr) begin
            n_fail++;
            $display("FAIL %s idle_hold: line_o=%h address_o=%h, required %h %h",
                     name, line_o, address_o, exp_buf, exp_addr);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            address_i = $urandom;
            read_i    = 1'($urandom_range(0, 1));
            write_i   = 1'($urandom_range(0, 1));
            line_i    = rnd256();
            burst_i   = rnd64();
            resp_i    = 1'($urandom_range(0, 1));
            step();
        end
        exp_addr = '0;
        exp_buf  = '0;
        n_checks++;
        if (resp_o !== 1'b0 || read_o !== 1'b0 || write_o !== 1'b0 || address_o !== 32'h0 ||
            line_o !== 256'h0 || burst_o !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: resp=%b rd=%b wr=%b addr=%h line=%h burst=%h, required all 0",
                     resp_o, read_o, write_o, address_o, line_o, burst_o);
        end
        rst     = 1'b0;
        read_i  = 1'b0;
        write_i = 1'b0;
        resp_i  = 1'b0;
        step();
        n_checks++;
        if (resp_o !== 1'b0 || read_o !== 1'b0 || write_o !== 1'b0 || line_o !== 256'h0) begin
            n_fail++;
            $display("FAIL reset_idle: resp=%b rd=%b wr=%b line=%h, required IDLE with zero outputs",
                     resp_o, read_o, write_o, line_o);
        end
    endtask

    task automatic test_fill_no_gaps();
        transfer(1'b0, 32'h0000_1234, {64'hA3, 64'hA2, 64'hA1, 64'hA0}, 0, 32'h0, 1'b0, "fill_no_gaps");
        n_checks++;
        if (exp_addr !== 32'h0000_1220) begin
            n_fail++;
            $display("FAIL fill_no_gaps model_addr: got %h, required 00001220", exp_addr);
        end
    endtask

    task automatic test_fill_gaps();
        // ack pattern 1,0,0,1,1,0,1 (bit 0 first)
        transfer(1'b0, $urandom, rnd256(), 1, 32'h0000_0059, 1'b0, "fill_gaps");
    endtask

    task automatic test_writeback();
        // ack every other cycle: 0,1,0,1,...
        transfer(1'b1, $urandom, rnd256(), 1, 32'hAAAA_AAAA, 1'b0, "writeback");
    endtask

    task automatic test_simultaneous();
        logic [31:0] a;
        a = $urandom;
        transfer(1'b1, a, rnd256(), 0, 32'h0, 1'b1, "simul_write");
        transfer(1'b0, a, rnd256(), 2, 32'h0, 1'b0, "simul_fill");
    endtask

    task automatic test_abort();
        read_i    = 1'b1;
        write_i   = 1'b0;
        address_i = $urandom;
        step();
        for (int i = 0; i < 2; i++) begin
            resp_i  = 1'b1;
            burst_i = rnd64();
            step();
        end
        rst     = 1'b1;
        resp_i  = 1'b1;
        burst_i = rnd64();
        step();
        rst      = 1'b0;
        read_i   = 1'b0;
        resp_i   = 1'b0;
        exp_addr = '0;
        exp_buf  = '0;
        n_checks++;
        if (read_o !== 1'b0 || resp_o !== 1'b0 || line_o !== 256'h0 || address_o !== 32'h0) begin
            n_fail++;
            $display("FAIL abort_reset: read_o=%b resp_o=%b line=%h addr=%h, required all 0",
                     read_o, resp_o, line_o, address_o);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if (resp_o !== 1'b0 || read_o !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_quiet cyc=%0d: resp_o=%b read_o=%b, required 0 0", i, resp_o, read_o);
            end
        end
    endtask

    task automatic test_stray_acks();
        read_i  = 1'b0;
        write_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            resp_i    = 1'($urandom_range(0, 1));
            burst_i   = rnd64();
            address_i = $urandom;
            line_i    = rnd256();
            step();
            n_checks++;
            if (resp_o !== 1'b0 || read_o !== 1'b0 || write_o !== 1'b0 ||
                line_o !== exp_buf || address_o !== exp_addr) begin
                n_fail++;
                $display("FAIL stray_ack cyc=%0d: resp=%b rd=%b wr=%b line=%h addr=%h, required 0 0 0 %h %h",
                         i, resp_o, read_o, write_o, line_o, address_o, exp_buf, exp_addr);
            end
        end
        resp_i = 1'b0;
    endtask

    task automatic test_random();
        for (int t = 0; t < 24; t++) begin
            bit wr;
            wr = 1'($urandom_range(0, 1));
            transfer(wr, $urandom, rnd256(), 2, 32'h0, 1'b0, wr ? "rand_write" : "rand_fill");
        end
    endtask

    task automatic test_back_to_back();
        transfer(1'b0, $urandom, rnd256(), 0, 32'h0, 1'b0, "b2b_fill0");
        transfer(1'b1, $urandom, rnd256(), 0, 32'h0, 1'b0, "b2b_write");
        transfer(1'b0, $urandom, rnd256(), 0, 32'h0, 1'b0, "b2b_fill1");
    endtask

    initial begin
        rst       = 1'b1;
        address_i = '0;
        read_i    = 1'b0;
        write_i   = 1'b0;
        line_i    = '0;
        burst_i   = '0;
        resp_i    = 1'b0;
        exp_addr  = '0;
        exp_buf   = '0;
        test_reset();
        test_fill_no_gaps();
        test_fill_gaps();
        test_writeback();
        test_simultaneous();
        test_stray_acks();
        test_abort();
        test_stray_acks();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
